if_fetch_buffer: RTL and testbench
==================================

Name: if_fetch_buffer

Overview:
- Sits directly downstream of the IF stage, between IF's PC output and the ID stage.
- Accepts fetch PCs from IF and issues instruction-memory reads.
- Buffers each returned {pc, instruction} pair in a small in-order FIFO and presents entries to ID with a valid/ready handshake.
- Handles redirect flushes, including discarding an in-flight memory response.

Parameters:
- DEPTH, 2, number of FIFO entries (legal range 1..8); sets the count/pointer widths.
- XLEN, 32, width of PC and instruction words.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- if_pc  in  XLEN  PC offered by IF
- if_valid  in  1  if_pc is a fetch request
- if_ready  out  1  PC accepted this cycle; IF advances its PC only when if_valid && if_ready
- flush  in  1  redirect: discard all buffered and in-flight fetches
- imem_read  out  1  memory read request, registered
- imem_address  out  XLEN  read address, registered
- imem_rdata  in  XLEN  read data, valid when imem_resp=1
- imem_resp  in  1  one-cycle completion pulse
- id_valid  out  1  an entry is presented to ID
- id_pc  out  XLEN  PC of the presented entry
- id_instr  out  XLEN  instruction word of the presented entry
- id_ready  in  1  ID consumes the entry this cycle

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, count=0, head/tail pointers=0, imem_read=0, imem_address=0.
  - FIFO storage cleared, so id_valid=0, id_pc=0, id_instr=0.
  - rst dominates every other input. An in-flight read is abandoned without waiting for imem_resp; a response arriving afterwards is ignored.
- State machine: IDLE, REQ, DROP.
- if_ready = !flush && state==IDLE && count<DEPTH. The decision is combinational from the registered state and count.
- IDLE:
  - On if_valid && if_ready: req_pc<=if_pc, imem_address<=if_pc, imem_read<=1, go to REQ.
  - The slot is reserved implicitly: pops only decrease count, so the later push always fits.
- REQ:
  - imem_read and imem_address are held stable until the imem_resp cycle, inclusive.
  - On imem_resp && !flush: push {req_pc, imem_rdata} at tail, imem_read<=0, go to IDLE.
  - On imem_resp && flush: discard the data, imem_read<=0, go to IDLE.
  - On flush && !imem_resp: go to DROP with imem_read held at 1. The memory protocol forbids withdrawing a request.
- DROP:
  - if_ready=0.
  - On imem_resp: discard the data, imem_read<=0, go to IDLE.
  - A flush in DROP has no further effect.
- Output and pop:
  - id_valid = (count!=0); id_pc/id_instr are driven from the head entry.
  - Pop occurs when id_valid && id_ready && !flush.
- Flush:
  - count, head and tail are set to 0 at the edge; flush beats a same-cycle pop and push.
  - id_valid is 0 in the following cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count is a ($clog2(DEPTH)+1)-bit value.
- Latency (accept at edge N, imem_resp in cycle N+1): push at edge N+1, id_valid=1 in cycle N+1+1.
- Throughput: at most one fetch per 2 cycles. The next accept is possible in the cycle after imem_resp.
- Full FIFO (count==DEPTH): if_ready=0 until a pop. Buffered entries are never lost or reordered.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: in REQ, with imem_resp=1, count==0 and flush=0:
  - id_valid=1, id_pc=req_pc, id_instr=imem_rdata, all combinationally in the response cycle.
  - If id_ready=1, the entry is consumed and not pushed. If id_ready=0, it is pushed as normal.
  - Saves one cycle of fetch-to-decode latency.
- Undefined: id_valid is purely registered (count!=0), with no combinational path from imem to ID outputs.

Test Plan:
- Reset then single fetch: if_pc=0x60, memory returns 0x00000013 one cycle after imem_read -> imem_address=0x60; id_valid=1, id_pc=0x60, id_instr=0x00000013 two cycles after accept (one cycle with FETCH_BYPASS_EN).
- Backpressure, DEPTH=2, id_ready=0, PCs 0x60/0x64/0x68 offered -> two entries buffered; if_ready=0 with count=2 and 0x68 not accepted; raising id_ready pops 0x60 then 0x64 in order, then 0x68 is accepted.
- Flush during wait: accept 0x60, memory delays imem_resp by 3 cycles, flush asserted in the first REQ cycle -> imem_read stays 1 until imem_resp, nothing pushed, id_valid stays 0, if_ready returns 1 after imem_resp.
- Flush with full FIFO and same-cycle imem_resp, with id_ready=1 -> count=0 next cycle, response data discarded, no pop observed by ID.
- Simultaneous push and pop: count=1, imem_resp and id_ready in the same cycle -> count stays 1, head advances, order preserved across pointer wrap (run 10 fetches 0x60..0x84).
- Reset mid-operation: rst in REQ with a response arriving in the same cycle -> all outputs 0, state IDLE, data not pushed.

Source files
------------

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer
//   Decouples the IF stage from ID. Each PC accepted from IF becomes a single
//   instruction-memory read; the returned {pc, instruction} pair is queued in
//   a small in-order FIFO and presented to ID with a valid/ready handshake.
//   A redirect (flush) empties the FIFO and discards an in-flight response.
//
//   Optional feature, selected by the macro FETCH_BYPASS_EN:
//     defined   - when the FIFO is empty, a memory response is forwarded to ID
//                 combinationally in the response cycle (saves one cycle).
//     undefined - ID outputs come purely from registered FIFO state.
module if_fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  // IF side
  input  logic [XLEN-1:0] if_pc,
  input  logic            if_valid,
  output logic            if_ready,
  // redirect
  input  logic            flush,
  // instruction memory
  output logic            imem_read,
  output logic [XLEN-1:0] imem_address,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_resp,
  // ID side
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  input  logic            id_ready
);

  // A one-entry FIFO still needs a 1-bit pointer so the array index is legal.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  // IDLE: free to accept a PC.  REQ: read outstanding.
  // DROP: read outstanding but already flushed; its data will be thrown away.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              imem_read_reg, imem_read_next;
  logic [XLEN-1:0]   imem_address_reg, imem_address_next;
  logic [XLEN-1:0]   req_pc_reg, req_pc_next;

  logic [CNT_W-1:0]  count_reg;
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;

  logic [XLEN-1:0]   pc_mem    [DEPTH];
  logic [XLEN-1:0]   instr_mem [DEPTH];
  logic [DEPTH-1:0]  wr_en;

  logic              fifo_valid;
  logic              resp_ok;
  logic              push;
  logic              pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake and FIFO control
  // ---------------------------------------------------------------------------
  // Accepting while count<DEPTH is safe: pops only ever lower count, so the
  // slot needed by the eventual response is guaranteed to still be free.
  assign if_ready   = !flush && (state_reg == IDLE) && (count_reg < DEPTH_CNT);

  assign fifo_valid = (count_reg != '0);

  // A response that survives the flush check; DROP responses never qualify.
  assign resp_ok    = (state_reg == REQ) && imem_resp && !flush;

  // Flush wins over a pop in the same cycle.
  assign pop        = fifo_valid && id_ready && !flush;

`ifdef FETCH_BYPASS_EN
  logic bypass_hit;
  logic bypass_take;

  // Empty FIFO plus a good response: ID may see the data straight away.
  assign bypass_hit  = resp_ok && (count_reg == '0);
  // If ID takes it in the same cycle the entry never enters the FIFO.
  assign bypass_take = bypass_hit && id_ready;
  assign push        = resp_ok && !bypass_take;
`else
  assign push        = resp_ok;
`endif

  // One write strobe per entry, selected by the tail pointer.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (tail_reg == PTR_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Fetch state machine
  // ---------------------------------------------------------------------------
  // Next-state logic: request/address are held from accept through the
  // response cycle, since the memory protocol forbids withdrawing a request.
  always_comb begin
    state_next        = state_reg;
    imem_read_next    = imem_read_reg;
    imem_address_next = imem_address_reg;
    req_pc_next       = req_pc_reg;

    case (state_reg)
      IDLE: begin
        if (if_valid && if_ready) begin
          state_next        = REQ;
          imem_read_next    = 1'b1;
          imem_address_next = if_pc;
          req_pc_next       = if_pc;
        end
      end

      REQ: begin
        if (imem_resp) begin
          // Push (or discard on flush) is decided by resp_ok/push.
          state_next     = IDLE;
          imem_read_next = 1'b0;
        end else if (flush) begin
          // Keep the read asserted until the memory answers.
          state_next = DROP;
        end
      end

      DROP: begin
        if (imem_resp) begin
          state_next     = IDLE;
          imem_read_next = 1'b0;
        end
      end

      default: begin
        state_next     = IDLE;
        imem_read_next = 1'b0;
      end
    endcase
  end

  // State register for the fetch FSM and the registered memory request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      imem_read_reg    <= 1'b0;
      imem_address_reg <= '0;
      req_pc_reg       <= '0;
    end else begin
      state_reg        <= state_next;
      imem_read_reg    <= imem_read_next;
      imem_address_reg <= imem_address_next;
      req_pc_reg       <= req_pc_next;
    end
  end

  assign imem_read    = imem_read_reg;
  assign imem_address = imem_address_reg;

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  // Occupancy and pointers; flush empties the FIFO and beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      if (push) begin
        tail_reg <= ptr_inc(tail_reg);
      end
      if (pop) begin
        head_reg <= ptr_inc(head_reg);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage; cleared on reset so the ID outputs read back as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          pc_mem[i]    <= req_pc_reg;
          instr_mem[i] <= imem_rdata;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ID outputs
  // ---------------------------------------------------------------------------
  // Present the head entry; with bypass enabled an empty FIFO may instead
  // forward the response arriving this cycle.
  always_comb begin
    id_valid = fifo_valid;
    id_pc    = pc_mem[head_reg];
    id_instr = instr_mem[head_reg];
`ifdef FETCH_BYPASS_EN
    if (bypass_hit) begin
      id_valid = 1'b1;
      id_pc    = req_pc_reg;
      id_instr = imem_rdata;
    end
`endif
  end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb_if_fetch_buffer
//   Self-checking bench for if_fetch_buffer (DEPTH=2, XLEN=32). A small
//   instruction-memory model answers reads after a programmable latency, and
//   a scoreboard queue holds the {pc, instr} pairs ID is expected to receive,
//   in order. Honours FETCH_BYPASS_EN when the same macro is defined.
module tb_if_fetch_buffer;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] if_pc;
  logic            if_valid;
  logic            if_ready;
  logic            flush;
  logic            imem_read;
  logic [XLEN-1:0] imem_address;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_resp;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;
  logic            id_ready;

  always #5 clk = ~clk;

  if_fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_pc        (if_pc),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .flush        (flush),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_instr     (id_instr),
    .id_ready     (id_ready)
  );

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  int     errors = 0;
  int     checks = 0;
  entry_t sb[$];

  // memory model / in-flight tracking
  int              mem_lat = 1;
  int              mem_wait = 0;
  bit              ready_on_resp = 0;
  bit              infl = 0;
  bit              infl_drop = 0;
  logic [XLEN-1:0] infl_pc = '0;

  // per-cycle observations
  logic            got_ready, got_valid, got_read;
  logic [XLEN-1:0] got_pc, got_instr;
  bit              want_valid, popped, pop_bad, accepted;
  entry_t          want;

  function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] a);
    if (a == 32'h60) return 32'h0000_0013;
    return {~a[23:0], 8'h13};
  endfunction

  // Drive one clock cycle: memory model answers, DUT is sampled mid-cycle,
  // scoreboard and in-flight model are updated, then step past the edge.
  task automatic drive_cycle();
    bit push_now;
    if (imem_read === 1'b1) begin
      mem_wait++;
      imem_resp = (mem_wait >= mem_lat);
    end else begin
      mem_wait  = 0;
      imem_resp = 1'b0;
    end
    imem_rdata = imem_resp ? instr_of(imem_address) : '0;
    if (ready_on_resp) id_ready = imem_resp;
    #1;
    got_ready = if_ready;
    got_valid = id_valid;
    got_read  = imem_read;
    got_pc    = id_pc;
    got_instr = id_instr;
    accepted  = (if_valid && got_ready === 1'b1 && !rst);
    push_now  = imem_resp && infl && !infl_drop && !flush && !rst;
    want_valid = (sb.size() != 0);
`ifdef FETCH_BYPASS_EN
    if (push_now && sb.size() == 0) want_valid = 1'b1;
`endif
    popped  = (got_valid === 1'b1) && id_ready && !flush && !rst;
    pop_bad = 1'b0;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (push_now) sb.push_back({infl_pc, instr_of(infl_pc)});
      if (popped) begin
        if (sb.size() != 0) want = sb.pop_front();
        else begin
          pop_bad = 1'b1;
          want    = '0;
        end
      end
    end
    if (rst) begin
      infl      = 1'b0;
      infl_drop = 1'b0;
    end else begin
      if (imem_resp && infl) begin
        infl      = 1'b0;
        infl_drop = 1'b0;
      end else if (flush && infl) begin
        infl_drop = 1'b1;
      end
      if (accepted) begin
        infl      = 1'b1;
        infl_drop = 1'b0;
        infl_pc   = if_pc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_cycle();
    drive_cycle();
    rst = 1'b0;
    #1;
    checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL reset_read got=%b want=0", imem_read); end
    checks++; if (imem_address !== '0) begin errors++; $display("FAIL reset_addr got=%h want=0", imem_address); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", id_valid); end
    checks++; if (id_pc !== '0 || id_instr !== '0) begin errors++; $display("FAIL reset_data got pc=%h instr=%h want 0/0", id_pc, id_instr); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got=%b want=1", if_ready); end
    $display("test_reset done");
  endtask

  task automatic test_single_fetch();
    int n_pop = 0;
    mem_lat = 1; id_ready = 1'b1; flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if_valid = (c == 0);
      if_pc    = 32'h60;
      drive_cycle();
      if (c == 0) begin
        checks++; if (!accepted) begin errors++; $display("FAIL sf_accept got if_ready=%b want=1", got_ready); end
        checks++; if (imem_read !== 1'b1 || imem_address !== 32'h60) begin errors++; $display("FAIL sf_imem got read=%b addr=%h want 1/00000060", imem_read, imem_address); end
      end
      if (c == 1) begin
        checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL sf_read_drop got=%b want=0", imem_read); end
      end
      checks++; if (got_valid !== want_valid) begin errors++; $display("FAIL sf_valid cyc=%0d got=%b want=%b", c, got_valid, want_valid); end
      if (popped) begin
        n_pop++;
        checks++; if (pop_bad || got_pc !== want.pc || got_instr !== want.instr) begin errors++; $display("FAIL sf_pop got pc=%h instr=%h want pc=%h instr=%h", got_pc, got_instr, want.pc, want.instr); end
      end
    end
    checks++; if (n_pop != 1 || want.instr !== 32'h13) begin errors++; $display("FAIL sf_count got pops=%0d instr=%h want 1/00000013", n_pop, want.instr); end
    $display("test_single_fetch done pops=%0d", n_pop);
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] pcs [3];
    int idx = 0;
    int n_pop = 0;
    pcs[0] = 32'h60; pcs[1] = 32'h64; pcs[2] = 32'h68;
    mem_lat = 1; flush = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if_valid = (idx < 3);
      if_pc    = (idx < 3) ? pcs[idx] : '0;
      id_ready = (c >= 8);
      drive_cycle();
      if (accepted) idx++;
      if (c == 7) begin
        checks++; if (got_ready !== 1'b0 || idx != 2) begin errors++; $display("FAIL bp_full got if_ready=%b accepted=%0d want 0/2", got_ready, idx); end
      end
      checks++; if (got_valid !== want_valid) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b want=%b", c, got_valid, want_valid); end
      if (popped) begin
        n_pop++;
        checks++; if (pop_bad || got_pc !== want.pc || got_instr !== want.instr) begin errors++; $display("FAIL bp_pop got pc=%h instr=%h want pc=%h instr=%h", got_pc, got_instr, want.pc, want.instr); end
      end
    end
    checks++; if (n_pop != 3 || idx != 3 || sb.size() != 0) begin errors++; $display("FAIL bp_total got pops=%0d accepted=%0d left=%0d want 3/3/0", n_pop, idx, sb.size()); end
    $display("test_backpressure done pops=%0d", n_pop);
  endtask

  task automatic test_flush_wait();
    mem_lat = 3; id_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if_valid = (c == 0);
      if_pc    = 32'h60;
      flush    = (c == 1);
      drive_cycle();
      if (c == 0) begin
        checks++; if (!accepted) begin errors++; $display("FAIL fw_accept got if_ready=%b want=1", got_ready); end
      end
      if (c >= 1 && c <= 3) begin
        checks++; if (got_read !== 1'b1 || got_ready !== 1'b0) begin errors++; $display("FAIL fw_hold cyc=%0d got read=%b if_ready=%b want 1/0", c, got_read, got_ready); end
      end
      if (c == 4) begin
        checks++; if (got_read !== 1'b0 || got_ready !== 1'b1) begin errors++; $display("FAIL fw_release got read=%b if_ready=%b want 0/1", got_read, got_ready); end
      end
      checks++; if (got_valid !== 1'b0) begin errors++; $display("FAIL fw_valid cyc=%0d got=%b want=0", c, got_valid); end
    end
    flush = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL fw_sb got left=%0d want 0", sb.size()); end
    $display("test_flush_wait done");
  endtask

  task automatic test_flush_full();
    int n_pop = 0;
    mem_lat = 1;
    for (int c = 0; c < 10; c++) begin
      if_valid = (c == 0 || c == 2 || c == 5);
      if_pc    = (c == 0) ? 32'h100 : (c == 2) ? 32'h104 : 32'h108;
      flush    = (c == 3);
      id_ready = (c >= 3);
      drive_cycle();
      if (c == 0 || c == 2 || c == 5) begin
        checks++; if (!accepted) begin errors++; $display("FAIL ff_accept cyc=%0d got if_ready=%b want=1", c, got_ready); end
      end
      if (c == 3) begin
        checks++; if (got_valid !== 1'b1) begin errors++; $display("FAIL ff_before got valid=%b want=1", got_valid); end
      end
      if (c == 4) begin
        checks++; if (got_valid !== 1'b0 || got_ready !== 1'b1) begin errors++; $display("FAIL ff_after got valid=%b if_ready=%b want 0/1", got_valid, got_ready); end
      end
      checks++; if (got_valid !== want_valid) begin errors++; $display("FAIL ff_valid cyc=%0d got=%b want=%b", c, got_valid, want_valid); end
      if (popped) begin
        n_pop++;
        checks++; if (pop_bad || got_pc !== want.pc || got_instr !== want.instr) begin errors++; $display("FAIL ff_pop got pc=%h instr=%h want pc=%h instr=%h", got_pc, got_instr, want.pc, want.instr); end
      end
    end
    flush = 1'b0;
    checks++; if (n_pop != 1 || want.pc !== 32'h108) begin errors++; $display("FAIL ff_total got pops=%0d last=%h want 1/00000108", n_pop, want.pc); end
    $display("test_flush_full done pops=%0d", n_pop);
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int n_pop = 0;
    int n_simul = 0;
    mem_lat = 1; flush = 1'b0; ready_on_resp = 1'b1;
    for (int c = 0; c < 26; c++) begin
      if (c == 24) begin
        ready_on_resp = 1'b0;
        id_ready      = 1'b1;
      end
      if_valid = (idx < 10);
      if_pc    = 32'h60 + 32'(4 * idx);
      drive_cycle();
      if (accepted) idx++;
      if (popped && imem_resp) n_simul++;
      checks++; if (got_valid !== want_valid) begin errors++; $display("FAIL b2b_valid cyc=%0d got=%b want=%b", c, got_valid, want_valid); end
      if (popped) begin
        n_pop++;
        checks++; if (pop_bad || got_pc !== want.pc || got_instr !== want.instr) begin errors++; $display("FAIL b2b_pop got pc=%h instr=%h want pc=%h instr=%h", got_pc, got_instr, want.pc, want.instr); end
      end
    end
    checks++; if (idx != 10 || n_pop != 10 || n_simul < 9 || sb.size() != 0) begin errors++; $display("FAIL b2b_total got accepted=%0d pops=%0d simul=%0d left=%0d want 10/10/>=9/0", idx, n_pop, n_simul, sb.size()); end
    $display("test_back_to_back done pops=%0d simul=%0d", n_pop, n_simul);
  endtask

  task automatic test_reset_mid();
    int n_pop = 0;
    mem_lat = 1; flush = 1'b0; id_ready = 1'b0;
    if_valid = 1'b1; if_pc = 32'h200;
    drive_cycle();
    checks++; if (!accepted) begin errors++; $display("FAIL rm_accept got if_ready=%b want=1", got_ready); end
    if_valid = 1'b0;
    rst = 1'b1;
    drive_cycle();
    rst = 1'b0;
    #1;
    checks++; if (imem_read !== 1'b0 || imem_address !== '0) begin errors++; $display("FAIL rm_imem got read=%b addr=%h want 0/0", imem_read, imem_address); end
    checks++; if (id_valid !== 1'b0 || id_pc !== '0 || id_instr !== '0) begin errors++; $display("FAIL rm_id got valid=%b pc=%h instr=%h want 0/0/0", id_valid, id_pc, id_instr); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL rm_idle got if_ready=%b want=1", if_ready); end
    id_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if_valid = (c == 1);
      if_pc    = 32'h300;
      drive_cycle();
      checks++; if (got_valid !== want_valid) begin errors++; $display("FAIL rm_valid cyc=%0d got=%b want=%b", c, got_valid, want_valid); end
      if (popped) begin
        n_pop++;
        checks++; if (pop_bad || got_pc !== want.pc || got_instr !== want.instr) begin errors++; $display("FAIL rm_pop got pc=%h instr=%h want pc=%h instr=%h", got_pc, got_instr, want.pc, want.instr); end
      end
    end
    checks++; if (n_pop != 1 || want.pc !== 32'h300) begin errors++; $display("FAIL rm_total got pops=%0d last=%h want 1/00000300", n_pop, want.pc); end
    $display("test_reset_mid done pops=%0d", n_pop);
  endtask

  initial begin
    rst        = 1'b1;
    if_valid   = 1'b0;
    if_pc      = '0;
    flush      = 1'b0;
    imem_resp  = 1'b0;
    imem_rdata = '0;
    id_ready   = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_fetch();
    test_backpressure();
    test_flush_wait();
    test_flush_full();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
